// File: rtl/qerv_ifetch.sv
// qerv_ifetch: instruction fetch unit between the PC/control stage and a
// Wishbone instruction bus. Accepts halfword-aligned fetch addresses,
// issues word-aligned bus reads and reassembles 32-bit instructions that
// straddle a word boundary. A one-word buffer lets consecutive fetches to
// the same word skip the bus.
//
// Ports:
//   clk        clock, all state on rising edge
//   i_rst_n    asynchronous active-low reset
//   i_cpu_cyc  fetch request, held with stable i_cpu_adr until o_cpu_ack
//   i_cpu_adr  fetch address (bit 0 ignored, bit 1 ignored when WITH_C=0)
//   i_flush    invalidate the instruction buffer
//   o_cpu_rdt  fetched instruction, valid with o_cpu_ack
//   o_cpu_ack  single-cycle response strobe
//   o_wb_cyc   bus cycle request
//   o_wb_adr   word-aligned bus address
//   i_wb_rdt   bus read data
//   i_wb_ack   single-cycle bus acknowledge
module qerv_ifetch #(
  parameter bit          WITH_C    = 1'b1,
  parameter logic [31:0] RESET_ADR = 32'd0
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_cyc,
  input  logic [31:0] i_cpu_adr,
  input  logic        i_flush,
  output logic [31:0] o_cpu_rdt,
  output logic        o_cpu_ack,
  output logic        o_wb_cyc,
  output logic [31:0] o_wb_adr,
  input  logic [31:0] i_wb_rdt,
  input  logic        i_wb_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] buf_data_r, buf_data_s;
  logic [29:0] buf_tag_r, buf_tag_s;
  logic        buf_vld_r, buf_vld_s;
  logic        flush_pend_r, flush_pend_s;
  logic        offset_r, offset_s;
  logic [15:0] hi_r, hi_s;
  logic        wb_cyc_r, wb_cyc_s;
  logic [31:0] wb_adr_r, wb_adr_s;
  logic        cpu_ack_r, cpu_ack_s;
  logic [31:0] cpu_rdt_r, cpu_rdt_s;

  logic [29:0] word_s;
  logic        offset_req_s;
  logic        hit_s;
  logic        fill_s;
  logic [15:0] buf_hi_s;
  logic [15:0] bus_hi_s;
  logic        unused_s;

  // A halfword whose two low bits are not 2'b11 is a complete compressed instruction
  function automatic logic is_compressed(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

  assign word_s       = i_cpu_adr[31:2];
  assign offset_req_s = WITH_C & i_cpu_adr[1];
  assign hit_s        = buf_vld_r & (buf_tag_r == word_s);
  assign buf_hi_s     = buf_data_r[31:16];
  assign bus_hi_s     = i_wb_rdt[31:16];
  assign unused_s     = i_cpu_adr[0];

  // Next-state, output and buffer update logic
  always_comb begin
    state_s    = state_r;
    buf_data_s = buf_data_r;
    buf_tag_s  = buf_tag_r;
    buf_vld_s  = buf_vld_r;
    offset_s   = offset_r;
    hi_s       = hi_r;
    wb_cyc_s   = wb_cyc_r;
    wb_adr_s   = wb_adr_r;
    cpu_ack_s  = 1'b0;
    cpu_rdt_s  = cpu_rdt_r;
    fill_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (i_cpu_cyc) begin
          offset_s = offset_req_s;
          if (!hit_s) begin
            state_s  = FETCH_LO;
            wb_cyc_s = 1'b1;
            wb_adr_s = {word_s, 2'b00};
          end else if (!offset_req_s) begin
            state_s   = RESP;
            cpu_ack_s = 1'b1;
            cpu_rdt_s = buf_data_r;
          end else if (is_compressed(buf_hi_s)) begin
            state_s   = RESP;
            cpu_ack_s = 1'b1;
            cpu_rdt_s = {16'h0000, buf_hi_s};
          end else begin
            // Low half is already buffered; only the next word is needed
            state_s  = FETCH_HI;
            wb_cyc_s = 1'b1;
            wb_adr_s = {word_s + 30'd1, 2'b00};
            hi_s     = buf_hi_s;
          end
        end else begin
          state_s = IDLE;
        end
      end

      FETCH_LO: begin
        if (i_wb_ack) begin
          fill_s   = 1'b1;
          wb_cyc_s = 1'b0;
          if (!i_cpu_cyc) begin
            state_s = IDLE;
          end else if (!offset_r) begin
            state_s   = RESP;
            cpu_ack_s = 1'b1;
            cpu_rdt_s = i_wb_rdt;
          end else if (is_compressed(bus_hi_s)) begin
            state_s   = RESP;
            cpu_ack_s = 1'b1;
            cpu_rdt_s = {16'h0000, bus_hi_s};
          end else begin
            // Bus cycle request stays low for one cycle before the second word
            state_s  = FETCH_HI;
            wb_adr_s = {wb_adr_r[31:2] + 30'd1, 2'b00};
            hi_s     = bus_hi_s;
          end
        end else begin
          state_s = FETCH_LO;
        end
      end

      FETCH_HI: begin
        if (!wb_cyc_r) begin
          if (i_cpu_cyc) begin
            wb_cyc_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else if (i_wb_ack) begin
          fill_s   = 1'b1;
          wb_cyc_s = 1'b0;
          if (i_cpu_cyc) begin
            state_s   = RESP;
            cpu_ack_s = 1'b1;
            cpu_rdt_s = {i_wb_rdt[15:0], hi_r};
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = FETCH_HI;
        end
      end

      RESP: begin
        state_s = IDLE;
      end

      default: begin
        state_s  = IDLE;
        wb_cyc_s = 1'b0;
      end
    endcase

    // A flush seen during the fetch keeps the filled word invalid
    if (fill_s) begin
      buf_data_s = i_wb_rdt;
      buf_tag_s  = wb_adr_r[31:2];
      buf_vld_s  = ~flush_pend_r;
    end else begin
      buf_data_s = buf_data_s;
    end

    if (i_flush) begin
      buf_vld_s = 1'b0;
    end else begin
      buf_vld_s = buf_vld_s;
    end

    flush_pend_s = ((state_s == FETCH_LO) || (state_s == FETCH_HI)) &&
                   (flush_pend_r || i_flush);
  end

  // State and output registers
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r      <= IDLE;
      buf_data_r   <= 32'd0;
      buf_tag_r    <= 30'd0;
      buf_vld_r    <= 1'b0;
      flush_pend_r <= 1'b0;
      offset_r     <= 1'b0;
      hi_r         <= 16'd0;
      wb_cyc_r     <= 1'b0;
      wb_adr_r     <= RESET_ADR;
      cpu_ack_r    <= 1'b0;
      cpu_rdt_r    <= 32'd0;
    end else begin
      state_r      <= state_s;
      buf_data_r   <= buf_data_s;
      buf_tag_r    <= buf_tag_s;
      buf_vld_r    <= buf_vld_s;
      flush_pend_r <= flush_pend_s;
      offset_r     <= offset_s;
      hi_r         <= hi_s;
      wb_cyc_r     <= wb_cyc_s;
      wb_adr_r     <= wb_adr_s;
      cpu_ack_r    <= cpu_ack_s;
      cpu_rdt_r    <= cpu_rdt_s;
    end
  end

  assign o_cpu_rdt = cpu_rdt_r;
  assign o_cpu_ack = cpu_ack_r;
  assign o_wb_cyc  = wb_cyc_r;
  assign o_wb_adr  = wb_adr_r;

endmodule

// File: doc/qerv_ifetch.md
# qerv_ifetch

Instruction fetch unit between the core's PC/control stage and the external Wishbone instruction bus. Takes the halfword-aligned fetch address produced by the control stage and issues word-aligned bus cycles. Reassembles 32-bit instructions that straddle a word boundary when compressed instructions are enabled. Returns one aligned 32-bit instruction word per request, using a one-word buffer to avoid refetching the word shared by consecutive halfword-aligned fetches.

## Interface
Parameters:
- WITH_C, 1, enable halfword-aligned fetch; when 0, i_cpu_adr[1] is ignored and treated as 0
- RESET_ADR, 32'd0, reset value of o_wb_adr

Ports:
- clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_cpu_cyc  in  1  fetch request; held high with stable i_cpu_adr until o_cpu_ack
- i_cpu_adr  in  32  fetch address (bit 0 ignored)
- i_flush  in  1  invalidate instruction buffer (fence.i / trap)
- o_cpu_rdt  out  32  fetched instruction, valid when o_cpu_ack=1
- o_cpu_ack  out  1  single-cycle response strobe
- o_wb_cyc  out  1  bus cycle request
- o_wb_adr  out  32  bus address, bits [1:0] always 0
- i_wb_rdt  in  32  bus read data
- i_wb_ack  in  1  bus acknowledge, single cycle

## Operation
- Buffer: buf_data[31:0], buf_tag[29:0], buf_vld. Hit = buf_vld & buf_tag==word address.
- States: IDLE, FETCH_LO, FETCH_HI, RESP.
- IDLE, i_cpu_cyc=1, W=i_cpu_adr[31:2]:
  - Aligned case (adr[1]=0 or WITH_C=0): hit -> RESP with rdt=buf_data; miss -> FETCH_LO at W.
  - Offset case (adr[1]=1): upper half H=word(W)[31:16], taken from the buffer or from FETCH_LO at W.
    - If H[1:0]!=2'b11 (compressed): rdt={16'h0,H}.
    - Else go to FETCH_HI at W+1; rdt={word(W+1)[15:0],H}.
    - W+1 wraps 30'h3FFFFFFF -> 0.
- FETCH_LO/FETCH_HI: o_wb_cyc=1, o_wb_adr={word,2'b00}. On i_wb_ack:
  - Load the buffer with i_wb_rdt and its tag; set buf_vld.
  - Proceed to FETCH_HI (offset uncompressed after FETCH_LO) or RESP.
  - FETCH_HI never reads the buffer, even on a tag hit (single buffer holds one word).
- RESP: o_cpu_ack=1 for one cycle with o_cpu_rdt; next state IDLE.
- The request is not re-evaluated in the cycle after RESP, so back-to-back requests need one idle cycle.
- i_cpu_cyc low during FETCH_*:
  - The bus cycle completes and the buffer fills.
  - No o_cpu_ack is issued; return to IDLE.
- i_flush: buf_vld<=0 the next edge.
  - Flush wins over a same-cycle fill.
  - A fetch in flight completes and responds with bus data but leaves buf_vld=0.
- i_wb_ack outside FETCH_* is ignored.

## Timing
- Reset (async assert, sync release): state IDLE, o_wb_cyc=0, o_wb_adr=RESET_ADR, o_cpu_ack=0, o_cpu_rdt=0, buf_vld=0, buf_tag=0, buf_data=0.
- All outputs registered.
- Hit latency: request seen at edge N, o_cpu_ack high in cycle N+1.
- Miss: o_wb_cyc high from cycle N+1 until the cycle of i_wb_ack (ack at cycle M); o_cpu_ack in cycle M+1.
- Straddle, both words missed, acks at M1 and M2:
  - o_wb_cyc drops for the cycle M1+1.
  - FETCH_HI starts at M1+1 with o_wb_cyc high from M1+2.
  - o_cpu_ack at M2+1.
- Straddle with buffer hit for W: FETCH_HI cyc from N+1; ack at M+1.
- o_wb_adr updates only on entry to FETCH_* and is held otherwise.
- o_cpu_rdt holds its last value outside ack.

## Test plan
- Reset mid-FETCH_LO (o_wb_cyc=1): assert i_rst_n=0 -> o_wb_cyc=0 immediately (async), buf_vld=0; after release, 0x100 request misses.
- Aligned miss then hit: adr 0x100 with bus returning 0x00A00093 after 3 cycles -> one bus cycle to 0x100, ack with 0x00A00093; repeat 0x100 -> ack in 1 cycle, no o_wb_cyc.
- Compressed offset: buffer holds 0x0001_4501 @0x200; request 0x202 -> no bus cycle, rdt=0x00000001.
- Straddle: request 0x206, word 0x204=0x0093_xxxx... with H=0x0093 (low bits 11), word 0x208=0x1234_00A0 -> bus cycles 0x204 then 0x208, rdt=0x00A00093, buffer tag = 0x208>>2.
- Wrap: straddle at 0xFFFFFFFE -> second bus cycle to 0x00000000.
- Flush and abort:
  - i_flush coincident with i_wb_ack -> ack issued, next request to the same word refetches.
  - i_cpu_cyc dropped mid-fetch -> no o_cpu_ack.
  - WITH_C=0 with 0x102 -> bus address 0x100.
